// File: rtl/ce_bridge_pkg.sv
// Shared constants for the CE-phase transfer buffer (ce_bridge_fifo).
// Sticky-flag bit positions match the telemetry status word.
package ce_bridge_pkg;
  localparam int unsigned FLAG_OVF = 0;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_COL = 2;
  localparam int unsigned FLAG_W   = 3;

  typedef logic [FLAG_W-1:0] ce_flags_t;
endpackage

// File: rtl/ce_guard_chk.sv
// Producer/consumer separation counter and sticky ovf/unf/col flags.
// Built only when CE_BRIDGE_CHECKS_EN is defined.
module ce_guard_chk
  import ce_bridge_pkg::*;
#(
  parameter int GUARD = 1
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic              aen,
  input  logic              ben,
  input  logic              ovf_evt,
  input  logic              unf_evt,
  input  logic              clr,
  output logic [FLAG_W-1:0] flags
);
  localparam int SW = $clog2(GUARD + 1);

  logic [SW-1:0]     sep;
  logic              col_evt;
  logic [FLAG_W-1:0] evt;

  // sep reads one less than the edge distance to the last aen, so a ben
  // exactly GUARD edges after aen is clean and GUARD=1 flags only coincidence.
  assign col_evt = ben && (aen || (int'(sep) + 1 < GUARD));

  always_comb begin
    evt           = '0;
    evt[FLAG_OVF] = ovf_evt;
    evt[FLAG_UNF] = unf_evt;
    evt[FLAG_COL] = col_evt;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      sep   <= SW'(GUARD);
      flags <= '0;
    end else begin
      if (aen)                     sep <= '0;
      else if (sep != SW'(GUARD))  sep <= sep + 1'b1;
      flags <= (flags & {FLAG_W{~clr}}) | evt;
    end
  end

`ifndef SYNTHESIS
  always @(posedge aclk) begin
    if (arstn && col_evt) $error("%m: aen/ben collision at %0t", $time);
    if (arstn && ovf_evt) $error("%m: push dropped (overflow) at %0t", $time);
    if (arstn && unf_evt) $error("%m: pop while empty (underflow) at %0t", $time);
  end
`endif
endmodule

// File: rtl/ce_bridge_fifo.sv
// DEPTH-entry buffer between two clock-enable phases on one clock.
// CE_BRIDGE_CHECKS_EN builds the collision guard and sticky error flags.
module ce_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GUARD = 1
) (
  input  logic                       aclk,
  input  logic                       arstn,
  input  logic                       aen_i,
  input  logic [WIDTH-1:0]           adat_i,
  input  logic                       ben_i,
  output logic [WIDTH-1:0]           bdat_o,
  output logic                       bvld_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  input  logic                       clr_i,
  output logic                       ovf_o,
  output logic                       unf_o,
  output logic                       col_o
);
  import ce_bridge_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [LW-1:0]    level, level_nxt;
  logic             push, pop;

  // A pop on the same edge frees the slot a full-buffer push needs.
  assign pop  = ben_i && (level != '0);
  assign push = aen_i && ((level != LVL_FULL) || pop);

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (pop && !push) level_nxt = level - 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wptr] <= adat_i;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
      bdat_o  <= '0;
      bvld_o  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr   <= rptr + 1'b1;
        bdat_o <= mem[rptr];
      end
      bvld_o  <= pop;
      level   <= level_nxt;
      full_o  <= (level_nxt == LVL_FULL);
      empty_o <= (level_nxt == '0);
    end
  end

  assign level_o = level;

`ifdef CE_BRIDGE_CHECKS_EN
  logic [FLAG_W-1:0] flags;

  ce_guard_chk #(.GUARD(GUARD)) u_guard (
    .aclk    (aclk),
    .arstn   (arstn),
    .aen     (aen_i),
    .ben     (ben_i),
    .ovf_evt (aen_i && !push),
    .unf_evt (ben_i && (level == '0)),
    .clr     (clr_i),
    .flags   (flags)
  );

  assign ovf_o = flags[FLAG_OVF];
  assign unf_o = flags[FLAG_UNF];
  assign col_o = flags[FLAG_COL];
`else
  localparam int UNUSED_GUARD = GUARD;
  logic unused_clr;
  assign unused_clr = clr_i;
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
  assign col_o = 1'b0;
`endif
endmodule

// File: tb/tb_ce_bridge_fifo.sv
// Randomized/directed bench for ce_bridge_fifo against a queue-based model.
module tb_ce_bridge_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int GUARD = 3;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef CE_BRIDGE_CHECKS_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [16:0] RST_VEC = {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3'b000};

  logic             aclk = 1'b0, arstn = 1'b0, aen = 1'b0, ben = 1'b0, clr = 1'b0;
  logic [WIDTH-1:0] adat = '0, bdat;
  logic             bvld, full, empty, ovf, unf, col;
  logic [LW-1:0]    level;
  logic [16:0]      act;

  int n_vec = 0, n_bad = 0;

  // reference model: plain queue + sticky flags + last-aen edge number
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_dat = '0;
  bit m_vld, m_ovf, m_unf, m_col;
  int cyc = 0, last_a = -1000;

  ce_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .aclk(aclk), .arstn(arstn), .aen_i(aen), .adat_i(adat), .ben_i(ben),
    .bdat_o(bdat), .bvld_o(bvld), .full_o(full), .empty_o(empty),
    .level_o(level), .clr_i(clr), .ovf_o(ovf), .unf_o(unf), .col_o(col)
  );

  always #5 aclk = ~aclk;

  assign act = {bdat, bvld, level, full, empty, col, unf, ovf};

  function automatic logic [16:0] exp_vec();
    return {m_dat, m_vld, LW'(q.size()), q.size() == DEPTH, q.size() == 0,
            CHK && m_col, CHK && m_unf, CHK && m_ovf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dat = '0; m_vld = 0; m_ovf = 0; m_unf = 0; m_col = 0;
    last_a = cyc - 1000;
  endtask

  task automatic model_edge(input bit a, input logic [7:0] d, input bit b, input bit c);
    bit pop, push, col_e;
    cyc++;
    pop   = b && (q.size() > 0);
    push  = a && ((q.size() < DEPTH) || pop);
    col_e = b && (a || (cyc - last_a < GUARD));
    if (a) last_a = cyc;
    m_vld = pop;
    if (pop)  m_dat = q.pop_front();
    if (push) q.push_back(d);
    m_ovf = (m_ovf && !c) || (a && !push);
    m_unf = (m_unf && !c) || (b && !pop);
    m_col = (m_col && !c) || col_e;
  endtask

  task automatic step(input bit a, input logic [7:0] d, input bit b, input bit c);
    aen = a; adat = d; ben = b; clr = c;
    @(posedge aclk); #1;
    model_edge(a, d, b, c);
    aen = 0; ben = 0; clr = 0;
  endtask

  task automatic test_reset();
    arstn = 0; aen = 0; ben = 0; clr = 0;
    repeat (2) @(posedge aclk);
    #1;
    model_reset();
    n_vec++; if (act !== RST_VEC) begin n_bad++; $display("FAIL reset_state: got %h want %h", act, RST_VEC); end
    arstn = 1;
    step(0, 0, 0, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL reset_idle: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1, d[i], 0, 0);
      n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL fill_push: got %h want %h", act, exp_vec()); end
      n_vec++; if (level !== LW'(i + 1)) begin n_bad++; $display("FAIL fill_level: got %0d want %0d", level, i + 1); end
      repeat (3) begin
        step(0, 0, 0, 0);
        n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL fill_idle: got %h want %h", act, exp_vec()); end
      end
    end
    n_vec++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_after_4: got %b want 1", full); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL drain_pop: got %h want %h", act, exp_vec()); end
      n_vec++; if ({bvld, bdat} !== {1'b1, d[i]}) begin n_bad++; $display("FAIL drain_data: got %b/%h want 1/%h", bvld, bdat, d[i]); end
      step(0, 0, 0, 0);
      n_vec++; if (bvld !== 1'b0) begin n_bad++; $display("FAIL bvld_pulse: got %b want 0", bvld); end
      n_vec++; if (level !== LW'(3 - i)) begin n_bad++; $display("FAIL drain_level: got %0d want %0d", level, 3 - i); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d [4];
    d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) begin
      step(1, d[i], 0, 0);
      n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL ovf_fill: got %h want %h", act, exp_vec()); end
    end
    step(1, 8'h55, 0, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL ovf_push: got %h want %h", act, exp_vec()); end
    n_vec++; if ({ovf, level} !== {CHK, LW'(4)}) begin n_bad++; $display("FAIL ovf_flag_level: got %b/%0d want %b/4", ovf, level, CHK); end
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL ovf_pop: got %h want %h", act, exp_vec()); end
      n_vec++; if (bdat !== d[i]) begin n_bad++; $display("FAIL ovf_data: got %h want %h", bdat, d[i]); end
      step(0, 0, 0, 0);
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL unf_pop: got %h want %h", act, exp_vec()); end
    n_vec++; if ({bvld, bdat, unf} !== {1'b0, 8'hA4, CHK}) begin n_bad++; $display("FAIL unf_hold: got %b/%h/%b want 0/a4/%b", bvld, bdat, unf, CHK); end
    step(0, 0, 0, 1);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL unf_clr: got %h want %h", act, exp_vec()); end
    n_vec++; if (unf !== 1'b0) begin n_bad++; $display("FAIL unf_cleared: got %b want 0", unf); end
  endtask

  task automatic test_same_edge();
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 8'hB3, 1, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL same_lvl2: got %h want %h", act, exp_vec()); end
    n_vec++; if ({level, bvld, bdat, col} !== {LW'(2), 1'b1, 8'hB1, CHK}) begin n_bad++; $display("FAIL same_lvl2_fields: got %0d/%b/%h/%b want 2/1/b1/%b", level, bvld, bdat, col, CHK); end
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    n_vec++; if (bdat !== 8'hB2) begin n_bad++; $display("FAIL same_drain1: got %h want b2", bdat); end
    step(0, 0, 1, 0);
    n_vec++; if (bdat !== 8'hB3) begin n_bad++; $display("FAIL same_drain2: got %h want b3", bdat); end
    step(0, 0, 0, 1);
    step(1, 8'hC1, 1, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL same_lvl0: got %h want %h", act, exp_vec()); end
    n_vec++; if ({level, unf, bvld, bdat} !== {LW'(1), CHK, 1'b0, 8'hB3}) begin n_bad++; $display("FAIL same_lvl0_fields: got %0d/%b/%b/%h want 1/%b/0/b3", level, unf, bvld, bdat, CHK); end
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    n_vec++; if (bdat !== 8'hC1) begin n_bad++; $display("FAIL same_lvl0_data: got %h want c1", bdat); end
  endtask

  task automatic test_guard();
    step(0, 0, 0, 1);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL guard_clr: got %h want %h", act, exp_vec()); end
    step(1, 8'hD1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL guard_sep2: got %h want %h", act, exp_vec()); end
    n_vec++; if ({col, bdat} !== {CHK, 8'hD1}) begin n_bad++; $display("FAIL guard_sep2_col: got %b/%h want %b/d1", col, bdat, CHK); end
    step(0, 0, 0, 1);
    n_vec++; if (col !== 1'b0) begin n_bad++; $display("FAIL guard_col_clr: got %b want 0", col); end
    step(1, 8'hD2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL guard_sep3: got %h want %h", act, exp_vec()); end
    n_vec++; if ({col, bdat} !== {1'b0, 8'hD2}) begin n_bad++; $display("FAIL guard_sep3_col: got %b/%h want 0/d2", col, bdat); end
  endtask

  task automatic test_wrap_reset();
    logic [7:0] x;
    for (int i = 0; i < 10; i++) begin
      x = 8'($urandom);
      step(1, x, 0, 0);
      n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL wrap_push: got %h want %h", act, exp_vec()); end
      step(0, 0, 1, 0);
      n_vec++; if ({bvld, bdat} !== {1'b1, x}) begin n_bad++; $display("FAIL wrap_data: got %b/%h want 1/%h", bvld, bdat, x); end
    end
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
    n_vec++; if (level !== LW'(3)) begin n_bad++; $display("FAIL wrap_level3: got %0d want 3", level); end
    #2 arstn = 0;
    #1;
    n_vec++; if (act !== RST_VEC) begin n_bad++; $display("FAIL async_reset: got %h want %h", act, RST_VEC); end
    model_reset();
    @(posedge aclk); #1;
    arstn = 1;
    step(0, 0, 0, 0);
    n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL post_reset: got %h want %h", act, exp_vec()); end
    n_vec++; if (level !== '0) begin n_bad++; $display("FAIL post_reset_level: got %0d want 0", level); end
  endtask

  task automatic test_random();
    bit a, b, c;
    for (int k = 0; k < 400; k++) begin
      a = $urandom_range(0, 99) < ((k < 200) ? 60 : 30);
      b = $urandom_range(0, 99) < ((k < 200) ? 30 : 60);
      c = $urandom_range(0, 15) == 0;
      step(a, 8'($urandom), b, c);
      n_vec++; if (act !== exp_vec()) begin n_bad++; $display("FAIL random_%0d: got %h want %h", k, act, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_same_edge();
    test_guard();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
